// File: rtl/ph_pkg.sv
// Shared constants for the pH alarm monitor: FSM encodings and register widths.
package ph_pkg;

  localparam int STREAK_W = 4;
  localparam int EVENT_W  = 8;

  localparam logic [1:0] NORMAL  = 2'b00;
  localparam logic [1:0] SUSPECT = 2'b01;
  localparam logic [1:0] ALARM   = 2'b10;

  function automatic logic [EVENT_W-1:0] satIncrement(input logic [EVENT_W-1:0] value);
    return (value == '1) ? value : value + EVENT_W'(1);
  endfunction

endpackage

// File: rtl/ph_streak_counter.sv
// Counts consecutive mild (P-only) samples; terminal flags that one more
// increment reaches the confirmation count.
module ph_streak_counter
  import ph_pkg::*;
#(
  parameter int CONFIRM_COUNT = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                incr,
  input  logic                clear,
  output logic [STREAK_W-1:0] streak,
  output logic                terminal
);

  localparam logic [STREAK_W-1:0] CONFIRM = STREAK_W'(CONFIRM_COUNT);

  // Increment holds at CONFIRM so the streak can never overshoot it.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      streak <= '0;
    end else if (load) begin
      streak <= STREAK_W'(1);
    end else if (incr && (streak != CONFIRM)) begin
      streak <= streak + STREAK_W'(1);
    end
  end

  assign terminal = ((streak + STREAK_W'(1)) == CONFIRM);

endmodule

// File: rtl/ph_alarm_monitor.sv
// pH alarm FSM: confirms alarms on a P streak or a single Q sample.
// Define PH_ALARM_HISTORY_EN to add the saturating eventCount output.
module ph_alarm_monitor
  import ph_pkg::*;
#(
  parameter int CONFIRM_COUNT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sampleValid,
  input  logic       abnormalityP,
  input  logic       abnormalityQ,
  input  logic       alarmAck,
  output logic       alarmActive,
  output logic       alarmP,
  output logic       alarmQ,
  output logic [1:0] state
`ifdef PH_ALARM_HISTORY_EN
  , output logic [EVENT_W-1:0] eventCount
`endif
);

  logic [1:0]          nextState;
  logic                nextP;
  logic                nextQ;
  logic                streakLoad;
  logic                streakIncr;
  logic                streakClear;
  logic                streakTerminal;
  logic [STREAK_W-1:0] streak;

  ph_streak_counter #(
    .CONFIRM_COUNT(CONFIRM_COUNT)
  ) streakCounter (
    .clock   (clock),
    .reset   (reset),
    .load    (streakLoad),
    .incr    (streakIncr),
    .clear   (streakClear),
    .streak  (streak),
    .terminal(streakTerminal)
  );

  // A critical Q sample always wins over streak bookkeeping.
  always_comb begin
    nextState   = state;
    nextP       = alarmP;
    nextQ       = alarmQ;
    streakLoad  = 1'b0;
    streakIncr  = 1'b0;
    streakClear = 1'b0;
    case (state)
      NORMAL: begin
        if (sampleValid) begin
          if (abnormalityQ) begin
            nextState = ALARM;
            nextQ     = 1'b1;
          end else if (abnormalityP) begin
            streakLoad = 1'b1;
            if (CONFIRM_COUNT == 1) begin
              nextState = ALARM;
              nextP     = 1'b1;
            end else begin
              nextState = SUSPECT;
            end
          end
        end
      end
      SUSPECT: begin
        if (sampleValid) begin
          if (abnormalityQ) begin
            nextState = ALARM;
            nextQ     = 1'b1;
          end else if (abnormalityP) begin
            streakIncr = 1'b1;
            if (streakTerminal) begin
              nextState = ALARM;
              nextP     = 1'b1;
            end
          end else begin
            streakClear = 1'b1;
            nextState   = NORMAL;
          end
        end
      end
      ALARM: begin
        if (alarmAck) begin
          nextState   = NORMAL;
          nextP       = 1'b0;
          nextQ       = 1'b0;
          streakClear = 1'b1;
        end else if (sampleValid && abnormalityQ) begin
          nextQ = 1'b1;
        end
      end
      default: begin
        nextState   = NORMAL;
        nextP       = 1'b0;
        nextQ       = 1'b0;
        streakClear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= NORMAL;
      alarmActive <= 1'b0;
      alarmP      <= 1'b0;
      alarmQ      <= 1'b0;
    end else begin
      state       <= nextState;
      alarmActive <= (nextState == ALARM);
      alarmP      <= nextP;
      alarmQ      <= nextQ;
    end
  end

`ifdef PH_ALARM_HISTORY_EN
  logic enterAlarm;

  assign enterAlarm = (nextState == ALARM) && (state != ALARM);

  always_ff @(posedge clock) begin
    if (reset) begin
      eventCount <= '0;
    end else if (enterAlarm) begin
      eventCount <= satIncrement(eventCount);
    end
  end
`endif

endmodule

// File: tb/tb_ph_alarm_monitor.sv
// Scoreboard bench for ph_alarm_monitor: directed vectors push expectations,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_ph_alarm_monitor;

  typedef struct {
    int         tag;
    bit         sel;
    string      name;
    logic [1:0] st;
    logic       act;
    logic       ap;
    logic       aq;
    logic [7:0] ec;
  } expect_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       sampleValid;
  logic       abnormalityP;
  logic       abnormalityQ;
  logic       alarmAck;

  logic       act0, ap0, aq0, act1, ap1, aq1;
  logic [1:0] st0, st1;
  logic [7:0] ec0, ec1;

  int         cycle = 0;
  int         testsRun = 0;
  int         testsFailed = 0;
  int         expEc = 0;
  expect_t    sb[$];

  ph_alarm_monitor #(.CONFIRM_COUNT(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .sampleValid (sampleValid),
    .abnormalityP(abnormalityP),
    .abnormalityQ(abnormalityQ),
    .alarmAck    (alarmAck),
    .alarmActive (act0),
    .alarmP      (ap0),
    .alarmQ      (aq0),
    .state       (st0)
`ifdef PH_ALARM_HISTORY_EN
    , .eventCount(ec0)
`endif
  );

  ph_alarm_monitor #(.CONFIRM_COUNT(1)) dutOne (
    .clock       (clock),
    .reset       (reset),
    .sampleValid (sampleValid),
    .abnormalityP(abnormalityP),
    .abnormalityQ(abnormalityQ),
    .alarmAck    (alarmAck),
    .alarmActive (act1),
    .alarmP      (ap1),
    .alarmQ      (aq1),
    .state       (st1)
`ifdef PH_ALARM_HISTORY_EN
    , .eventCount(ec1)
`endif
  );

`ifndef PH_ALARM_HISTORY_EN
  assign ec0 = 8'd0;
  assign ec1 = 8'd0;
`endif

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input expect_t e);
    logic [1:0] st;
    logic       act, ap, aq, ok;
    logic [7:0] ec;
    st  = e.sel ? st1  : st0;
    act = e.sel ? act1 : act0;
    ap  = e.sel ? ap1  : ap0;
    aq  = e.sel ? aq1  : aq0;
    ec  = e.sel ? ec1  : ec0;
    ok  = (st == e.st) && (act == e.act) && (ap == e.ap) && (aq == e.aq);
`ifdef PH_ALARM_HISTORY_EN
    ok  = ok && (ec == e.ec);
`endif
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL %s (cycle %0d): got st=%0d act=%0b p=%0b q=%0b ec=%0d, expected st=%0d act=%0b p=%0b q=%0b ec=%0d",
               e.name, cycle, st, act, ap, aq, ec, e.st, e.act, e.ap, e.aq, e.ec);
    end
  endtask

  // Monitor: expectations fall due in the cycle after their stimulus.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].tag <= cycle) begin
      expect_t e;
      e = sb.pop_front();
      if (e.tag < cycle) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: stale expectation, due cycle %0d, now %0d", e.name, e.tag, cycle);
      end else begin
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic p, input logic q, input logic ack,
                               input logic rst, input string name, input logic [1:0] st,
                               input logic act, input logic ap, input logic aq, input bit sel);
    expect_t e;
    sampleValid  = v;
    abnormalityP = p;
    abnormalityQ = q;
    alarmAck     = ack;
    reset        = rst;
    e.tag  = cycle + 1;
    e.sel  = sel;
    e.name = name;
    e.st   = st;
    e.act  = act;
    e.ap   = ap;
    e.aq   = aq;
    e.ec   = 8'(expEc);
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expEc = 0;
    applyStimulus(0, 0, 0, 0, 1, "reset0", 2'b00, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, "reset1", 2'b00, 0, 0, 0, 0);

    // Three P samples separated by invalid (ignored) cycles confirm an alarm.
    applyStimulus(1, 1, 0, 0, 0, "p1", 2'b01, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, "gap1", 2'b01, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, "p2", 2'b01, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, "gap2", 2'b01, 0, 0, 0, 0);
    expEc = 1;
    applyStimulus(1, 1, 0, 0, 0, "p3Alarm", 2'b10, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, "alarmHold", 2'b10, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, "ack1", 2'b00, 0, 0, 0, 0);

    // P, P, normal, P, P leaves streak 2: a further P confirms.
    applyStimulus(1, 1, 0, 0, 0, "sP1", 2'b01, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, "sP2", 2'b01, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, "sNorm", 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, "sP3", 2'b01, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, "sP4", 2'b01, 0, 0, 0, 0);
    expEc = 2;
    applyStimulus(1, 1, 0, 0, 0, "sP5Alarm", 2'b10, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, "ack2", 2'b00, 0, 0, 0, 0);

    // Single Q sample from NORMAL, then ack with a coincident Q sample.
    expEc = 3;
    applyStimulus(1, 0, 1, 0, 0, "qAlarm", 2'b10, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, "pInAlarm", 2'b10, 1, 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 0, "ackWithQ", 2'b00, 0, 0, 0, 0);

    // Q from SUSPECT beats the streak; ack outside ALARM is ignored.
    applyStimulus(1, 1, 0, 1, 0, "pWithAck", 2'b01, 0, 0, 0, 0);
    expEc = 4;
    applyStimulus(1, 1, 1, 0, 0, "suspQ", 2'b10, 1, 0, 1, 0);
    applyStimulus(1, 0, 1, 0, 0, "qInAlarm", 2'b10, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, "ack3", 2'b00, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, "ackNormal", 2'b00, 0, 0, 0, 0);

    // P-confirmed alarm later picks up the sticky Q flag.
    applyStimulus(1, 1, 0, 0, 0, "bP1", 2'b01, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, "bP2", 2'b01, 0, 0, 0, 0);
    expEc = 5;
    applyStimulus(1, 1, 0, 0, 0, "bP3", 2'b10, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, "bQ", 2'b10, 1, 1, 1, 0);

    // Reset mid-ALARM, even with a sample present, wins.
    expEc = 0;
    applyStimulus(1, 0, 1, 0, 1, "resetInAlarm", 2'b00, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, "afterReset", 2'b00, 0, 0, 0, 0);

    // Event counter saturates at 255 over 256 alarm/ack cycles.
    for (int i = 0; i < 256; i++) begin
      expEc = (expEc < 255) ? expEc + 1 : 255;
      applyStimulus(1, 0, 1, 0, 0, "satAlarm", 2'b10, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0, "satAck", 2'b00, 0, 0, 0, 0);
    end

    // CONFIRM_COUNT=1: a single P sample raises the alarm.
    expEc = 0;
    applyStimulus(0, 0, 0, 0, 1, "oneReset", 2'b00, 0, 0, 0, 1);
    expEc = 1;
    applyStimulus(1, 1, 0, 0, 0, "oneP", 2'b10, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, "oneAck", 2'b00, 0, 0, 0, 1);

    @(negedge clock);
    #1;
    testsRun++;
    if (sb.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ph_alarm_monitor.md
PH_ALARM_MONITOR -- requirements
Module: ph_alarm_monitor

Interface
REQ-001 SHALL have parameter CONFIRM_COUNT, default 3: the number of consecutive valid P-abnormal samples that confirm an alarm; legal range 1..15.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port sampleValid, input, 1 bit: the abnormality inputs carry a new pH sample this cycle.
REQ-005 SHALL have port abnormalityP, input, 1 bit: the sample is outside the narrow normal band (mild).
REQ-006 SHALL have port abnormalityQ, input, 1 bit: the sample is outside the wide normal band (critical).
REQ-007 SHALL have port alarmAck, input, 1 bit: operator acknowledge, sampled every cycle.
REQ-008 SHALL have port alarmActive, output, 1 bit: an alarm is raised.
REQ-009 SHALL have port alarmP, output, 1 bit: the alarm was confirmed by a P streak.
REQ-010 SHALL have port alarmQ, output, 1 bit: sticky flag, set if any valid Q-abnormal sample was seen since entering the alarm.
REQ-011 SHALL have port state, output, 2 bits: the current FSM state.
REQ-012 SHALL have port eventCount, output, 8 bits: the alarm-entry counter; present only with PH_ALARM_HISTORY_EN.

Function
REQ-013 SHALL implement the FSM states NORMAL=2'b00, SUSPECT=2'b01, ALARM=2'b10; 2'b11 is illegal and SHALL go to NORMAL on the next cycle.
REQ-014 SHALL ignore abnormality inputs in any cycle where sampleValid=0; such cycles SHALL leave the state and streak unchanged.
REQ-015 SHALL, in NORMAL or SUSPECT, move to ALARM on any valid sample with abnormalityQ=1, and set alarmQ=1; this rule has priority over the streak rules.
REQ-016 SHALL, in NORMAL, load streak=1 on a valid sample with P=1 and Q=0, going to SUSPECT, or to ALARM with alarmP=1 if CONFIRM_COUNT=1.
REQ-017 SHALL, in SUSPECT, increment streak on a valid sample with P=1 and Q=0; when the incremented value equals CONFIRM_COUNT it SHALL go to ALARM and set alarmP=1.
REQ-018 SHALL, in SUSPECT, clear streak to 0 and return to NORMAL on a valid sample with P=0 and Q=0.
REQ-019 SHALL treat Q=1 with P=0 as critical, handled per REQ-015.
REQ-020 SHALL, in ALARM, set alarmQ on a valid Q-abnormal sample; all other samples are ignored and alarmActive stays 1.
REQ-021 SHALL, in ALARM with alarmAck=1, go to NORMAL on the next edge, clearing alarmP, alarmQ and streak; a sample arriving in the same cycle SHALL be discarded.
REQ-022 SHALL ignore alarmAck outside ALARM.
REQ-023 SHALL drive all outputs from registers; alarmActive SHALL be 1 exactly when state=ALARM and SHALL rise one cycle after the confirming sample.
REQ-024 SHALL hold the streak in a 4-bit register, never exceeding CONFIRM_COUNT.

Reset
REQ-025 SHALL, while reset=1, drive state=NORMAL, streak=0, alarmActive=0, alarmP=0, alarmQ=0 and eventCount=0 on the next edge; reset has priority over all inputs, including mid-ALARM.

Configuration
REQ-026 SHALL, with PH_ALARM_HISTORY_EN defined, increment eventCount on every transition into ALARM, saturating at 255, cleared only by reset.
REQ-027 SHALL, with PH_ALARM_HISTORY_EN undefined, omit the eventCount port and its counter logic; all other behaviour is unchanged.

Structure
REQ-028 SHALL place the state encodings, the streak width (4) and the eventCount width (8) as constants in the shared package ph_pkg.
REQ-029 SHALL implement the streak logic as sub-module ph_streak_counter, with load, increment, clear and terminal-count outputs.

Verification
REQ-030 SHALL verify: CONFIRM_COUNT=3, three valid P-only samples separated by invalid cycles -> SUSPECT, SUSPECT, then ALARM with alarmP=1 one cycle after the third sample.
REQ-031 SHALL verify: P, P, normal, P, P (all valid) -> no alarm; state=SUSPECT with streak=2 at the end.
REQ-032 SHALL verify: from NORMAL, a single valid Q=1 sample -> ALARM next cycle, alarmQ=1, alarmP=0, and eventCount 0->1 with the macro defined.
REQ-033 SHALL verify: in ALARM, alarmAck=1 together with a valid Q sample -> NORMAL next cycle with alarmQ=0, and eventCount unchanged.
REQ-034 SHALL verify: reset asserted for one cycle during ALARM -> all outputs 0 and state=NORMAL on the next edge.
REQ-035 SHALL verify: 256 alarm/ack cycles -> eventCount saturates at 255; with CONFIRM_COUNT=1, a single P sample -> ALARM.
